// File: rtl/apb_const_arbiter.sv
// apb_const_arbiter: two-requester arbiter that reads a 64-bit constant (pi or e) over APB.
// Ports:
//   PCLK, PRESETn          clock and synchronous active-low reset
//   req0/req1, sel0/sel1   requester level requests and constant selects (0 = pi, 1 = e)
//   done0/done1, err       one-cycle completion pulse per requester; err = timed out
//   result                 last captured {PRWDATA1, PRWDATA2}
//   busy                   high outside IDLE
//   PSEL, PENABLE, PWRITE, PRWADDR, PRWDATA   APB master side (read-only)
//   PRWDATA1, PRWDATA2, PREADY                APB slave response
// Compile-time option: ARB_ROUND_ROBIN_EN selects round-robin arbitration (default fixed priority).
module apb_const_arbiter #(
    parameter logic [31:0] PI_ADDR = 32'h0000_0004,
    parameter logic [31:0] E_ADDR  = 32'h0000_0008,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        req0,
    input  logic        req1,
    input  logic        sel0,
    input  logic        sel1,
    output logic        done0,
    output logic        done1,
    output logic        err,
    output logic [63:0] result,
    output logic        busy,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PRWADDR,
    output logic [31:0] PRWDATA,
    input  logic [31:0] PRWDATA1,
    input  logic [31:0] PRWDATA2,
    input  logic        PREADY
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
    state_t state, state_nx;
    logic       gnt, gnt_nx, sel_r, err_r;
    logic [7:0] cnt;
    logic       take;
    assign take = state == IDLE && (req0 || req1);
`ifdef ARB_ROUND_ROBIN_EN
    // ptr names the requester preferred on a tie: the one not granted last
    logic ptr;
    assign gnt_nx = (req0 && req1) ? ptr : !req0;
    always_ff @(posedge PCLK)
        if (!PRESETn) ptr <= 1'b0;
        else if (take) ptr <= !gnt_nx;
`else
    assign gnt_nx = !req0;
`endif
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (req0 || req1) ? SETUP : IDLE;
            SETUP:   state_nx = ACCESS;
            ACCESS:  state_nx = (PREADY || cnt == 8'(TIMEOUT - 1)) ? DONE : ACCESS;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state  <= IDLE;
            gnt    <= 1'b0;
            sel_r  <= 1'b0;
            err_r  <= 1'b0;
            cnt    <= 8'd0;
            result <= 64'h0;
        end else begin
            state <= state_nx;
            if (take) begin
                gnt   <= gnt_nx;
                sel_r <= gnt_nx ? sel1 : sel0;
            end
            if (state == SETUP) cnt <= 8'd0;
            else if (state == ACCESS && !PREADY) cnt <= cnt + 8'd1;
            // err_r on leaving ACCESS is valid for the whole DONE cycle
            if (state == ACCESS) err_r <= !PREADY;
            if (state == ACCESS && PREADY) result <= {PRWDATA1, PRWDATA2};
        end
    end
    assign busy    = state != IDLE;
    assign PSEL    = state == SETUP || state == ACCESS;
    assign PENABLE = state == ACCESS;
    assign PWRITE  = 1'b0;
    assign PRWDATA = 32'h0;
    assign PRWADDR = PSEL ? (sel_r ? E_ADDR : PI_ADDR) : 32'h0;
    assign done0   = state == DONE && !gnt;
    assign done1   = state == DONE && gnt;
    assign err     = state == DONE && err_r;
endmodule

// File: doc/apb_const_arbiter.md
APB_CONST_ARBITER -- requirements
Module: apb_const_arbiter

Interface
REQ-001 SHALL have parameter PI_ADDR, default 32'h0000_0004, APB address of the pi constant register.
REQ-002 SHALL have parameter E_ADDR, default 32'h0000_0008, APB address of the e constant register.
REQ-003 SHALL have parameter TIMEOUT, default 15, maximum ACCESS-phase cycles waiting for PREADY (range 1..255).
REQ-004 SHALL use one clock and a reset that is synchronous and active-low.
REQ-005 PCLK  in  1  sole clock; all logic on rising edge.
REQ-006 PRESETn  in  1  synchronous active-low reset.
REQ-007 req0, req1  in  1 each  requester level request; held until matching done.
REQ-008 sel0, sel1  in  1 each  constant select (0 = pi, 1 = e); sampled at grant.
REQ-009 done0, done1  out  1 each  one-cycle completion pulse to the requester.
REQ-010 err  out  1  qualifies done: 1 = transfer timed out.
REQ-011 result  out  64  last captured constant {PRWDATA1, PRWDATA2}.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 PSEL, PENABLE, PWRITE  out  1 each  APB master controls; PWRITE is constant 0.
REQ-014 PRWADDR  out  32  APB address; PRWDATA  out  32  write data, constant 0.
REQ-015 PRWDATA1, PRWDATA2  in  32 each  upper/lower 32 bits of the constant from the slave.
REQ-016 PREADY  in  1  slave ready.

Function
REQ-017 FSM states SHALL be IDLE, SETUP, ACCESS, DONE, all registered.
REQ-018 IDLE: if any req is high, the FSM SHALL latch the granted requester ID and its sel, then go to SETUP next cycle; otherwise it stays in IDLE.
REQ-019 SETUP: PSEL=1, PENABLE=0, PRWADDR = sel ? E_ADDR : PI_ADDR; the FSM SHALL unconditionally go to ACCESS.
REQ-020 ACCESS: PSEL=1, PENABLE=1, PRWADDR held; when PREADY=1 is sampled, the block SHALL capture result <= {PRWDATA1, PRWDATA2} and go to DONE.
REQ-021 The timeout counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with PREADY=0; on reaching TIMEOUT, the FSM SHALL go to DONE with err set and result unchanged.
REQ-022 DONE: PSEL=0, PENABLE=0; the granted done SHALL pulse high for exactly one cycle with err valid; the FSM SHALL then return to IDLE.
REQ-023 Minimum latency SHALL be 4 cycles from a req sampled in IDLE to done, with PREADY high in the first ACCESS cycle.
REQ-024 err SHALL be 0 whenever both done signals are 0.
REQ-025 PRWADDR SHALL be 0 in IDLE and DONE.
REQ-026 If req drops mid-transfer, the transfer SHALL complete and done SHALL still pulse.
REQ-027 A requester still asserting req in the cycle after its done SHALL be treated as a new request.
REQ-028 sel changes after grant SHALL be ignored until the next grant.

Reset
REQ-029 When PRESETn=0 at a rising edge, the block SHALL enter IDLE, regardless of current state, including mid-transfer.
REQ-030 Reset values SHALL be: PSEL=0, PENABLE=0, PWRITE=0, PRWADDR=0, PRWDATA=0, done0=done1=0, err=0, busy=0, result=64'h0, timeout counter 0, round-robin pointer = requester 0 preferred.
REQ-031 A transfer interrupted by reset SHALL produce no done pulse.

Configuration
REQ-032 Macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy at compile time.
REQ-033 With ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the requester not granted last; the pointer SHALL update at each grant.
REQ-034 With ARB_ROUND_ROBIN_EN undefined, simultaneous requests SHALL always be granted to req0 (fixed priority), and no pointer register SHALL exist.

Verification
REQ-035 Scenario: req0=1, sel0=0; the bench slave returns 32'h400921CA/32'hC083126F with PREADY after 1 ACCESS cycle -> PRWADDR=32'h4 in SETUP, done0 at cycle 4, result=64'h400921CA_C083126F, err=0.
REQ-036 Scenario: req1=1, sel1=1 -> PRWADDR=32'h8, done1 pulses once, done0 stays 0.
REQ-037 Scenario: req0=req1=1 held for 3 transfers, ARB_ROUND_ROBIN_EN defined -> grant order 0,1,0; undefined -> grant order 0,0,0.
REQ-038 Scenario: PREADY stuck at 0, TIMEOUT=15 -> done pulses with err=1 after 15 ACCESS cycles, result unchanged, PSEL=0 next cycle.
REQ-039 Scenario: PRESETn=0 in ACCESS -> next cycle PSEL=PENABLE=0, busy=0, no done pulse; the subsequent request completes normally.
REQ-040 Scenario: req0 dropped during SETUP -> done0 still pulses once, and the FSM returns to IDLE.
